// File: rtl/ledctl_pkg.sv
// Shared types and helpers for the UART command nibbler.
package ledctl_pkg;

    // Nibble emitter states, in the order a byte walks through them.
    typedef enum logic [2:0] {
        EM_IDLE,
        EM_LOAD,
        EM_HI_STB,
        EM_HI_GAP,
        EM_LO_STB,
        EM_LO_GAP,
        EM_DONE
    } emit_state_e;

    // 8N1 receiver states.
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // ')' closes a command frame for the LED interpreter.
    localparam logic [7:0] TERM_CHAR_DEF = 8'h29;

    // Clock cycles per 16x oversampling tick; never below 1.
    function automatic int baud_div(input int clk_hz, input int baud);
        int d;
        d = clk_hz / (baud * 16);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with 16x oversampling. Emits a one-cycle rx_valid with
// the byte on a good stop bit, or a one-cycle rx_ferr when the stop bit is low.
module uart_rx_core
    import ledctl_pkg::*;
#(
    parameter int DIV = 325
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_ferr
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    logic          sync1_q, sync2_q, prev_q;
    logic [DW-1:0] div_q;
    logic          tick;
    logic          div_clr;

    rx_state_e     state_q, state_d;
    logic [3:0]    smp_q, smp_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    assign tick     = (div_q == DW'(DIV - 1));
    assign rx_valid = valid_q;
    assign rx_ferr  = ferr_q;
    assign rx_byte  = shift_q;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    // NOTE: sequential blocks use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, exactly like hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Oversampling tick divider, realigned to the detected start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (div_clr || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            smp_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            smp_q   <= smp_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic: start qualify at 8 ticks, data and stop at 16 ticks.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        smp_d   = smp_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        div_clr = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (!sync2_q && prev_q) begin
                    state_d = RX_START;
                    smp_d   = '0;
                    div_clr = 1'b1;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (smp_q == 4'd7) begin
                        smp_d   = '0;
                        bit_d   = '0;
                        state_d = sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        smp_d = smp_q + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (smp_q == 4'd15) begin
                        smp_d   = '0;
                        shift_d = {sync2_q, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_d = RX_STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        smp_d = smp_q + 4'd1;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (smp_q == 4'd15) begin
                        valid_d = sync2_q;
                        ferr_d  = !sync2_q;
                        state_d = RX_IDLE;
                    end else begin
                        smp_d = smp_q + 4'd1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_cmd_nibbler.sv
// Buffers one TERM_CHAR-terminated command frame from the UART and replays it
// to the LED interpreter as high-then-low nibbles on start_flag/read_flag/data_out.
module uart_cmd_nibbler
    import ledctl_pkg::*;
#(
    parameter int         CLK_HZ     = 50_000_000,
    parameter int         BAUD       = 9600,
    parameter int         DEPTH      = 32,
    parameter int         STROBE_CYC = 4,
    parameter logic [7:0] TERM_CHAR  = TERM_CHAR_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic       start_flag,
    output logic       read_flag,
    output logic [3:0] data_out,
    output logic       busy,
    output logic       frame_err,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
    localparam logic [AW:0] FULL_LEN = (AW + 1)'(DEPTH);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_ferr;

    uart_rx_core #(
        .DIV (baud_div(CLK_HZ, BAUD))
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart_rx  (uart_rx),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .rx_ferr  (rx_ferr)
    );

    assign frame_err = rx_ferr;

    // Receive side: circular buffer with the open frame at fstart_q..+len_q.
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] fstart_q;
    logic [AW:0]   len_q;
    logic          bad_q;
    logic          ovf_q;
    logic [AW-1:0] wr_addr;
    logic          full, is_term, frame_bad, frame_done, bad_term;

    assign wr_addr    = fstart_q + len_q[AW-1:0];
    assign full       = (len_q == FULL_LEN);
    assign is_term    = (rx_byte == TERM_CHAR);
    assign frame_bad  = full || bad_q;
    assign frame_done = rx_valid && is_term && !frame_bad;
    assign bad_term   = rx_valid && is_term && frame_bad;
    assign overflow   = ovf_q;

    // Emitter side signals.
    emit_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW:0]   idx_q, idx_d;
    logic [AW-1:0] cur_start_q, cur_start_d;
    logic [AW:0]   cur_len_q, cur_len_d;
    logic [7:0]    byte_q, byte_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] pend_start_q, pend_start_d;
    logic [AW:0]   pend_len_q, pend_len_d;
    logic          pend_drop;
    logic [AW-1:0] rd_addr;
    logic          last, cnt_end;

    assign rd_addr = cur_start_q + idx_q[AW-1:0];
    assign last    = (idx_q == cur_len_q - (AW + 1)'(1));
    assign cnt_end = (cnt_q == CW'(STROBE_CYC - 1));
    assign busy    = (state_q != EM_IDLE);

    // Frame buffer storage; only in-range bytes of a live frame are written.
    // NOTE: the byte array has no reset; len/pointers define which entries
    // are valid, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (rx_valid && !full) begin
            mem_q[wr_addr] <= rx_byte;
        end
    end

    // Frame length, start pointer and oversize tracking; overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fstart_q <= '0;
            len_q    <= '0;
            bad_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            ovf_q <= bad_term || pend_drop;
            if (rx_valid) begin
                if (is_term) begin
                    len_q <= '0;
                    bad_q <= 1'b0;
                    if (!frame_bad) begin
                        fstart_q <= wr_addr + AW'(1);
                    end
                end else if (full) begin
                    bad_q <= 1'b1;
                end else begin
                    len_q <= len_q + (AW + 1)'(1);
                end
            end
        end
    end

    // Emitter and pending-slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EM_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            byte_q       <= '0;
            pend_q       <= 1'b0;
            pend_start_q <= '0;
            pend_len_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            byte_q       <= byte_d;
            pend_q       <= pend_d;
            pend_start_q <= pend_start_d;
            pend_len_q   <= pend_len_d;
        end
    end

    // Frame handoff, emitter sequencing and nibble-bus outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        byte_d       = byte_q;
        pend_d       = pend_q;
        pend_start_d = pend_start_q;
        pend_len_d   = pend_len_q;
        pend_drop    = 1'b0;
        start_flag   = 1'b0;
        read_flag    = 1'b0;
        data_out     = 4'h0;

        // A held frame goes first; a fresh frame either starts or is held.
        if (state_q == EM_IDLE) begin
            if (pend_q) begin
                state_d      = EM_LOAD;
                idx_d        = '0;
                cur_start_d  = pend_start_q;
                cur_len_d    = pend_len_q;
                pend_d       = frame_done;
                pend_start_d = fstart_q;
                pend_len_d   = len_q + (AW + 1)'(1);
            end else if (frame_done) begin
                state_d     = EM_LOAD;
                idx_d       = '0;
                cur_start_d = fstart_q;
                cur_len_d   = len_q + (AW + 1)'(1);
            end
        end else if (frame_done) begin
            if (pend_q) begin
                pend_drop = 1'b1;
            end else begin
                pend_d       = 1'b1;
                pend_start_d = fstart_q;
                pend_len_d   = len_q + (AW + 1)'(1);
            end
        end

        unique case (state_q)
            EM_LOAD: begin
                data_out   = mem_q[rd_addr][7:4];
                start_flag = !last;
                byte_d     = mem_q[rd_addr];
                cnt_d      = '0;
                state_d    = EM_HI_STB;
            end
            EM_HI_STB: begin
                data_out   = byte_q[7:4];
                start_flag = !last;
                read_flag  = 1'b1;
                cnt_d      = cnt_q + CW'(1);
                if (cnt_end) begin
                    cnt_d   = '0;
                    state_d = EM_HI_GAP;
                end
            end
            EM_HI_GAP: begin
                data_out   = byte_q[3:0];
                start_flag = !last;
                cnt_d      = cnt_q + CW'(1);
                if (cnt_end) begin
                    cnt_d   = '0;
                    state_d = EM_LO_STB;
                end
            end
            EM_LO_STB: begin
                data_out   = byte_q[3:0];
                start_flag = !last;
                read_flag  = 1'b1;
                cnt_d      = cnt_q + CW'(1);
                if (cnt_end) begin
                    cnt_d   = '0;
                    state_d = EM_LO_GAP;
                end
            end
            EM_LO_GAP: begin
                data_out   = byte_q[3:0];
                start_flag = !last;
                cnt_d      = cnt_q + CW'(1);
                if (cnt_end) begin
                    cnt_d = '0;
                    if (last) begin
                        state_d = EM_DONE;
                    end else begin
                        idx_d   = idx_q + (AW + 1)'(1);
                        state_d = EM_LOAD;
                    end
                end
            end
            EM_DONE: begin
                state_d = EM_IDLE;
            end
            default: begin
            end
        endcase
    end

endmodule
